prbs_sync_checker: RTL and testbench
====================================

Name: prbs_sync_checker

Overview:
Receive-side PRBS checker. It pairs with the team's PRBS generator / error-injection path and checks a parallel PRBS word stream against a locally regenerated sequence. A self-synchronising hunt mode acquires the sequence. A free-running locked mode then counts bit errors without error multiplication. It sits at the receive end of link loopback tests and drives the error-detect flags and counters that the benches and the top level observe.

Parameters:
POLY_LEN, 7, LFSR length; the tap at stage POLY_LEN is always used.
TAP_B, 6, second feedback tap (1..POLY_LEN-1). The polynomial is x^POLY_LEN + x^TAP_B + 1.
DATA_W, 8, bits checked per valid cycle.
LOCK_CNT, 4, consecutive clean words in HUNT required to lock (1..255).
LOSS_CNT, 3, consecutive errored words in LOCKED required to drop lock (1..255).
CNT_W, 16, width of the bit-error counter.

Ports:
CLK  in  1  clock, all logic rising-edge.
RST  in  1  asynchronous, active-high reset.
DIN_VALID  in  1  DIN holds a word to check this cycle.
DIN  in  DATA_W  received word. DIN[DATA_W-1] is the oldest bit in time.
ERR_CLR  in  1  synchronous clear of BIT_ERR_CNT.
LOCKED  out  1  checker is in the LOCKED state.
ERR_DETECT  out  1  one-cycle pulse: the last checked word, evaluated in LOCKED, had at least one mismatched bit.
LOSS_OF_LOCK  out  1  one-cycle pulse on the LOCKED->HUNT transition.
BIT_ERR_CNT  out  CNT_W  saturating count of mismatched bits seen in LOCKED.

Behaviour:
- Reset values (asynchronous): LOCKED=0, ERR_DETECT=0, LOSS_OF_LOCK=0, BIT_ERR_CNT=0. The LFSR state s[POLY_LEN-1:0] is all zeros, the FSM is in HUNT, and both run counters are 0.
- Per-bit model, processing DIN from bit DATA_W-1 down to bit 0:
  - predicted bit p = s[POLY_LEN-1] ^ s[TAP_B-1], where s[0] is the newest bit.
  - the bit mismatches when received bit r != p.
  - next state is {s[POLY_LEN-2:0], x}, with x = r in HUNT and x = p in LOCKED.
- All DATA_W steps are evaluated combinationally within one cycle.
- When DIN_VALID=0, s, the FSM and the run counters hold and no pulse is generated.
- All outputs are registered. Every result appears exactly 1 cycle after the valid word is presented.
- HUNT:
  - A word is clean when it has zero mismatches AND the resulting s is non-zero. This non-zero rule rejects the all-zero lock trap.
  - A clean word increments clean_run; an unclean word clears it to 0.
  - When clean_run reaches LOCK_CNT, the FSM moves to LOCKED and LOCKED=1 on the next cycle. err_run is set to 0.
  - ERR_DETECT is never asserted in HUNT, and BIT_ERR_CNT is not updated.
- LOCKED:
  - Each mismatched bit adds 1 to BIT_ERR_CNT. A word with n mismatches adds n, i.e. the popcount.
  - The counter saturates at 2^CNT_W-1 and never wraps.
  - ERR_DETECT=1 for one cycle when n>0.
  - A word with n>0 increments err_run; a word with n=0 clears it.
  - When err_run reaches LOSS_CNT, the FSM moves to HUNT with LOCKED=0 and LOSS_OF_LOCK=1 for one cycle, and clean_run=0.
  - s is kept on the HUNT transition; the self-sync hunt continues from received bits.
  - The ERR_DETECT pulse for the word that caused loss of lock is still asserted.
- ERR_CLR:
  - On its own, BIT_ERR_CNT becomes 0 next cycle.
  - In the same cycle as a counted word, BIT_ERR_CNT becomes n for that word (clear, then add).
  - ERR_CLR has no effect on the FSM or on s.
- Reset asserted mid-operation returns every register to its reset value immediately. The lock sequence restarts from HUNT after RST deasserts.
- Invalid parameters are rejected at elaboration: TAP_B >= POLY_LEN, or LOCK_CNT or LOSS_CNT equal to 0.

Test Plan:
1. Defaults; feed continuous PRBS7 words (x^7+x^6+1, seed 7'h7F) with DIN_VALID=1 every cycle -> LOCKED=1 no later than the cycle after the 5th word; ERR_DETECT stays 0; BIT_ERR_CNT=0.
2. After lock, flip one bit of word 50 (models INJ_ERR) -> exactly one ERR_DETECT pulse, 1 cycle after that word; BIT_ERR_CNT=1; LOCKED stays 1; the following words give no further errors.
3. After lock, feed 3 consecutive words of all ones (errored) -> LOSS_OF_LOCK pulses once; LOCKED=0 after the 3rd word; BIT_ERR_CNT equals the sum of mismatches; resuming valid PRBS relocks within LOCK_CNT+1 words.
4. From reset, feed all-zero words indefinitely -> LOCKED never asserts. Toggling DIN_VALID 1/0 during a valid PRBS stream -> lock and counts are identical to the gap-free run.
5. CNT_W=4; after lock, inject 20 single-bit errors -> BIT_ERR_CNT saturates at 15. ERR_CLR in the same cycle as a 2-bit-error word -> BIT_ERR_CNT=2.
6. Assert RST for 1 cycle while LOCKED with BIT_ERR_CNT=5 -> all outputs go to 0 immediately, asynchronously; relock follows as in scenario 1.

Source files
------------

// File: rtl/prbs_sync_checker.sv
// Receive-side PRBS checker: self-synchronising hunt, then free-running locked compare with bit-error count.
// Latency: every result is registered and appears 1 cycle after the DIN_VALID word.
// Backpressure: none; every valid word is consumed, and idle cycles hold all state.
module prbs_sync_checker #(
    parameter int POLY_LEN = 7,
    parameter int TAP_B    = 6,
    parameter int DATA_W   = 8,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              DIN_VALID,
    input  logic [DATA_W-1:0] DIN,
    input  logic              ERR_CLR,
    output logic              LOCKED,
    output logic              ERR_DETECT,
    output logic              LOSS_OF_LOCK,
    output logic [CNT_W-1:0]  BIT_ERR_CNT
);

    localparam int NW    = $clog2(DATA_W + 1);
    localparam int RUN_W = 8;
    localparam int SUM_W = ((CNT_W > NW) ? CNT_W : NW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (POLY_LEN < 2 || TAP_B < 1 || TAP_B >= POLY_LEN ||
        LOCK_CNT < 1 || LOCK_CNT > 255 || LOSS_CNT < 1 || LOSS_CNT > 255 ||
        DATA_W < 1 || CNT_W < 1) begin : g_param_check
        $error("prbs_sync_checker: invalid parameter set");
    end

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [POLY_LEN-1:0] s_q, s_d, s_walk;
    logic [RUN_W-1:0]    clean_run_q, clean_run_d;
    logic [RUN_W-1:0]    err_run_q, err_run_d;
    logic [NW-1:0]       mis_cnt;
    logic                pred;
    logic                det_d, loss_d;
    logic [SUM_W-1:0]    cnt_sum;
    logic [CNT_W-1:0]    cnt_d;

    // Walk the word oldest-bit first; in HUNT the received bit feeds the register, in LOCKED the prediction does.
    always_comb begin
        s_walk  = s_q;
        mis_cnt = '0;
        pred    = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            pred    = s_walk[POLY_LEN-1] ^ s_walk[TAP_B-1];
            mis_cnt = mis_cnt + NW'(DIN[i] ^ pred);
            s_walk  = {s_walk[POLY_LEN-2:0], (state_q == ST_LOCKED) ? pred : DIN[i]};
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        clean_run_d = clean_run_q;
        err_run_d   = err_run_q;
        det_d       = 1'b0;
        loss_d      = 1'b0;
        if (DIN_VALID) begin
            s_d = s_walk;
            case (state_q)
                ST_HUNT: begin
                    // A zero register predicts zeros forever, so an all-zero result never counts as clean.
                    if (mis_cnt == '0 && s_walk != '0) begin
                        if (clean_run_q == RUN_W'(LOCK_CNT - 1)) begin
                            state_d     = ST_LOCKED;
                            clean_run_d = '0;
                            err_run_d   = '0;
                        end else begin
                            clean_run_d = clean_run_q + RUN_W'(1);
                        end
                    end else begin
                        clean_run_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (mis_cnt != '0) begin
                        det_d = 1'b1;
                        if (err_run_q == RUN_W'(LOSS_CNT - 1)) begin
                            state_d     = ST_HUNT;
                            loss_d      = 1'b1;
                            err_run_d   = '0;
                            clean_run_d = '0;
                        end else begin
                            err_run_d = err_run_q + RUN_W'(1);
                        end
                    end else begin
                        err_run_d = '0;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // Clear happens before the add, so a clear alongside a counted word leaves exactly that word's errors.
    always_comb begin
        cnt_sum = ERR_CLR ? '0 : SUM_W'(BIT_ERR_CNT);
        if (DIN_VALID && state_q == ST_LOCKED) begin
            cnt_sum = cnt_sum + SUM_W'(mis_cnt);
        end
        cnt_d = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_HUNT;
            s_q          <= '0;
            clean_run_q  <= '0;
            err_run_q    <= '0;
            LOCKED       <= 1'b0;
            ERR_DETECT   <= 1'b0;
            LOSS_OF_LOCK <= 1'b0;
            BIT_ERR_CNT  <= '0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            clean_run_q  <= clean_run_d;
            err_run_q    <= err_run_d;
            LOCKED       <= (state_d == ST_LOCKED);
            ERR_DETECT   <= det_d;
            LOSS_OF_LOCK <= loss_d;
            BIT_ERR_CNT  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_prbs_sync_checker.sv
// Bench for prbs_sync_checker: PRBS7 source, scoreboard queue of expected outputs, vector table and corner sequences.
module tb_prbs_sync_checker;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;

    logic        clk;
    logic        rst;
    logic        din_valid;
    logic [7:0]  din;
    logic        err_clr;
    logic        locked, err_detect, loss_of_lock;
    logic [15:0] bit_err_cnt;
    logic        locked4, err_detect4, loss_of_lock4;
    logic [3:0]  bit_err_cnt4;

    prbs_sync_checker dut (
        .CLK(clk), .RST(rst), .DIN_VALID(din_valid), .DIN(din), .ERR_CLR(err_clr),
        .LOCKED(locked), .ERR_DETECT(err_detect), .LOSS_OF_LOCK(loss_of_lock),
        .BIT_ERR_CNT(bit_err_cnt)
    );

    prbs_sync_checker #(.CNT_W(4)) dut4 (
        .CLK(clk), .RST(rst), .DIN_VALID(din_valid), .DIN(din), .ERR_CLR(err_clr),
        .LOCKED(locked4), .ERR_DETECT(err_detect4), .LOSS_OF_LOCK(loss_of_lock4),
        .BIT_ERR_CNT(bit_err_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic locked;
        logic det;
        logic loss;
        int   cnt;
        int   cnt4;
    } exp_t;

    typedef struct {
        logic       vld;
        logic [7:0] mask;
        logic       clr;
        logic       e_locked;
        logic       e_det;
        logic       e_loss;
        int         e_cnt;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] g_s;
    logic [6:0] m_s;
    logic       m_locked;
    int         m_clean, m_err, m_cnt, m_cnt4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s = '0; m_locked = 1'b0; m_clean = 0; m_err = 0; m_cnt = 0; m_cnt4 = 0;
        g_s = 7'h7F;
        sb_q.delete();
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic clr, output exp_t e);
        int   n;
        logic p;
        logic was_locked;
        n = 0;
        e.det = 1'b0;
        e.loss = 1'b0;
        was_locked = m_locked;
        if (v) begin
            for (int i = 7; i >= 0; i--) begin
                p = m_s[6] ^ m_s[5];
                if (d[i] != p) n++;
                m_s = {m_s[5:0], was_locked ? p : d[i]};
            end
            if (!was_locked) begin
                if (n == 0 && m_s != 7'd0) m_clean++;
                else m_clean = 0;
                if (m_clean == LOCK_CNT) begin
                    m_locked = 1'b1; m_clean = 0; m_err = 0;
                end
            end else begin
                e.det = (n > 0);
                if (n > 0) m_err++;
                else m_err = 0;
                if (m_err == LOSS_CNT) begin
                    m_locked = 1'b0; e.loss = 1'b1; m_clean = 0; m_err = 0;
                end
            end
        end
        if (clr) begin
            m_cnt = 0; m_cnt4 = 0;
        end
        if (v && was_locked) begin
            m_cnt  = (m_cnt + n > 65535) ? 65535 : m_cnt + n;
            m_cnt4 = (m_cnt4 + n > 15) ? 15 : m_cnt4 + n;
        end
        e.locked = m_locked;
        e.cnt = m_cnt;
        e.cnt4 = m_cnt4;
    endtask

    // Drive one cycle, push the expectation, then compare once the registered result is visible.
    task automatic cycle(input logic v, input logic [7:0] d, input logic clr);
        exp_t e;
        din_valid = v; din = d; err_clr = clr;
        model_step(v, d, clr, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("sb_locked", locked, e.locked);
        chk("sb_det", err_detect, e.det);
        chk("sb_loss", loss_of_lock, e.loss);
        chk("sb_cnt", bit_err_cnt, e.cnt);
        chk("sb_locked4", locked4, e.locked);
        chk("sb_det4", err_detect4, e.det);
        chk("sb_loss4", loss_of_lock4, e.loss);
        chk("sb_cnt4", bit_err_cnt4, e.cnt4);
    endtask

    task automatic gen_word(output logic [7:0] w);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            b = g_s[6] ^ g_s[5];
            g_s = {g_s[5:0], b};
            w[i] = b;
        end
    endtask

    task automatic prbs_cycle(input logic [7:0] mask, input logic clr);
        logic [7:0] w;
        gen_word(w);
        cycle(1'b1, w ^ mask, clr);
    endtask

    task automatic do_reset();
        rst = 1'b1; din_valid = 1'b0; din = '0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vec_t       tbl [0:19];
        logic [7:0] w;
        int         det_pulses, n_exp, lock_seen;

        tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[4]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[6]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[7]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        tbl[8]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[10] = '{1'b1, 8'h81, 1'b1, 1'b1, 1'b1, 1'b0, 2};
        tbl[11] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        tbl[12] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 3};
        tbl[13] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 4};
        tbl[14] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 5};
        tbl[15] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5};
        tbl[16] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5};
        tbl[17] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5};
        tbl[18] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5};
        tbl[19] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5};

        rst = 1'b1; din_valid = 1'b0; din = '0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_det", err_detect, 0);
        chk("rst_loss", loss_of_lock, 0);
        chk("rst_cnt", bit_err_cnt, 0);
        rst = 1'b0;
        model_reset();

        // Lock acquisition, then a single injected error on word 50.
        det_pulses = 0;
        for (int k = 1; k <= 60; k++) begin
            prbs_cycle((k == 50) ? 8'h08 : 8'h00, 1'b0);
            if (err_detect) det_pulses++;
            if (k == 4) chk("lock_w4", locked, 0);
            if (k == 5) chk("lock_w5", locked, 1);
            if (k == 50) begin
                chk("inj_det", err_detect, 1);
                chk("inj_cnt", bit_err_cnt, 1);
            end
        end
        chk("inj_pulses", det_pulses, 1);
        chk("inj_locked", locked, 1);

        // Three all-ones words force loss of lock; the stream then resumes.
        n_exp = 0;
        for (int k = 0; k < 3; k++) begin
            gen_word(w);
            n_exp += 8 - $countones(w);
            cycle(1'b1, 8'hFF, 1'b0);
            chk("ones_det", err_detect, 1);
            chk("ones_loss", loss_of_lock, (k == 2));
            chk("ones_locked", locked, (k != 2));
        end
        chk("ones_cnt", bit_err_cnt, 1 + n_exp);
        for (int k = 0; k < LOCK_CNT + 1; k++) prbs_cycle(8'h00, 1'b0);
        chk("relock", locked, 1);

        // All-zero input must never lock.
        do_reset();
        lock_seen = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 8'h00, 1'b0);
            if (locked) lock_seen++;
        end
        chk("zeros_nolock", lock_seen, 0);

        // Gapped stream gives the same lock point and count as the gap-free run.
        do_reset();
        det_pulses = 0;
        for (int k = 0; k < 30; k++) begin
            prbs_cycle((k == 19) ? 8'h40 : 8'h00, 1'b0);
            if (k == 3) chk("gap_lock_w4", locked, 0);
            if (k == 4) chk("gap_lock_w5", locked, 1);
            if (err_detect) det_pulses++;
            cycle(1'b0, 8'($urandom), 1'b0);
        end
        chk("gap_pulses", det_pulses, 1);
        chk("gap_cnt", bit_err_cnt, 1);

        // Saturation of the narrow counter, then clear together with a 2-bit error word.
        for (int k = 0; k < 20; k++) begin
            prbs_cycle(8'h02, 1'b0);
            prbs_cycle(8'h00, 1'b0);
        end
        chk("sat_cnt4", bit_err_cnt4, 15);
        chk("sat_cnt16", bit_err_cnt, 21);
        chk("sat_locked", locked, 1);
        prbs_cycle(8'h24, 1'b1);
        chk("clradd_cnt4", bit_err_cnt4, 2);
        chk("clradd_cnt16", bit_err_cnt, 2);

        // Vector table from reset.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (tbl[i].vld) prbs_cycle(tbl[i].mask, tbl[i].clr);
            else cycle(1'b0, 8'hA5, tbl[i].clr);
            chk($sformatf("tbl%0d_locked", i), locked, tbl[i].e_locked);
            chk($sformatf("tbl%0d_det", i), err_detect, tbl[i].e_det);
            chk($sformatf("tbl%0d_loss", i), loss_of_lock, tbl[i].e_loss);
            chk($sformatf("tbl%0d_cnt", i), bit_err_cnt, tbl[i].e_cnt);
        end

        // Asynchronous reset mid-cycle while locked with a count of 5.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_locked", locked, 0);
        chk("arst_det", err_detect, 0);
        chk("arst_loss", loss_of_lock, 0);
        chk("arst_cnt", bit_err_cnt, 0);
        chk("arst_cnt4", bit_err_cnt4, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int k = 1; k <= 5; k++) begin
            prbs_cycle(8'h00, 1'b0);
            if (k == 4) chk("arst_lock_w4", locked, 0);
            if (k == 5) chk("arst_lock_w5", locked, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
